// File: rtl/uart_tx_arbiter_if.sv
// Producer/serializer bundle for uart_tx_arbiter.
// master: requesters and serializer side; slave: the arbiter.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]    req;
  logic [NREQ*64-1:0] req_data;
  logic [NREQ-1:0]    ack;
  logic [63:0]        ser_data;
  logic               ser_start;
  logic               ser_done;
  logic               busy;
  logic [1:0]         grant_id;
  logic [15:0]        word_count;
  logic               timeout_err;

  modport master (
    output req, req_data, ser_done,
    input  ack, ser_data, ser_start, busy,
    input  grant_id, word_count, timeout_err
  );

  modport slave (
    input  req, req_data, ser_done,
    output ack, ser_data, ser_start, busy,
    output grant_id, word_count, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 64-bit serializer among NREQ producers.
// Optional watchdog on the serializer completion: define ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NREQ           = 2,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input logic              clock,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);

  if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
    $error("NREQ out of range");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
    $error("TIMEOUT_CYCLES must be positive");
  end

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          state_q, state_n;
  logic [1:0]      ptr_q, ptr_n;
  logic [1:0]      gid_q, gid_n;
  logic [63:0]     data_q, data_n;
  logic [NREQ-1:0] ack_q, ack_n;
  logic            start_q, start_n;
  logic            busy_q, busy_n;
  logic [15:0]     cnt_q, cnt_n;
  logic            terr_q, terr_n;
`ifdef ARB_TIMEOUT_EN
  logic [31:0]     tmo_q, tmo_n;
`endif

  logic [3:0]   req4;
  logic [255:0] rd;
  logic [2:0]   k;
  logic         hit;
  logic [1:0]   sel;
  logic [3:0]   onehot;
  logic [1:0]   nxt_ptr;
  logic         done_ok;

  // Scan from the highest offset down so the lowest offset wins.
  always_comb begin
    req4 = 4'(bus.req);
    rd   = 256'(bus.req_data);
    hit  = 1'b0;
    sel  = 2'd0;
    k    = 3'd0;
    for (int o = NREQ - 1; o >= 0; o--) begin
      k = {1'b0, ptr_q} + 3'(o);
      if (k >= 3'(NREQ)) k = k - 3'(NREQ);
      if (req4[k[1:0]]) begin
        hit = 1'b1;
        sel = k[1:0];
      end
    end
    onehot  = 4'b0001 << sel;
    nxt_ptr = (gid_q == 2'(NREQ - 1)) ? 2'd0 : gid_q + 2'd1;
    // The serializer cannot finish in the cycle it is started.
    done_ok = bus.ser_done && !start_q;
  end

  always_comb begin
    state_n = state_q;
    ptr_n   = ptr_q;
    gid_n   = gid_q;
    data_n  = data_q;
    ack_n   = '0;
    start_n = 1'b0;
    busy_n  = busy_q;
    cnt_n   = cnt_q;
    terr_n  = terr_q;
`ifdef ARB_TIMEOUT_EN
    tmo_n   = tmo_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (hit) begin
          state_n = S_WAIT;
          data_n  = rd[{sel, 6'd0} +: 64];
          gid_n   = sel;
          ack_n   = onehot[NREQ-1:0];
          start_n = 1'b1;
          busy_n  = 1'b1;
`ifdef ARB_TIMEOUT_EN
          tmo_n   = 32'd0;
`endif
        end
      end
      S_WAIT: begin
        if (done_ok) begin
          state_n = S_IDLE;
          cnt_n   = cnt_q + 16'd1;
          busy_n  = 1'b0;
          ptr_n   = nxt_ptr;
        end
`ifdef ARB_TIMEOUT_EN
        else if (tmo_q == 32'(TIMEOUT_CYCLES - 1)) begin
          state_n = S_IDLE;
          terr_n  = 1'b1;
          busy_n  = 1'b0;
          ptr_n   = nxt_ptr;
        end else begin
          tmo_n = tmo_q + 32'd1;
        end
`endif
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= 2'd0;
      gid_q   <= 2'd0;
      data_q  <= 64'd0;
      ack_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= 16'd0;
      terr_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      tmo_q   <= 32'd0;
`endif
    end else begin
      state_q <= state_n;
      ptr_q   <= ptr_n;
      gid_q   <= gid_n;
      data_q  <= data_n;
      ack_q   <= ack_n;
      start_q <= start_n;
      busy_q  <= busy_n;
      cnt_q   <= cnt_n;
      terr_q  <= terr_n;
`ifdef ARB_TIMEOUT_EN
      tmo_q   <= tmo_n;
`endif
    end
  end

  assign bus.ack         = ack_q;
  assign bus.ser_data    = data_q;
  assign bus.ser_start   = start_q;
  assign bus.busy        = busy_q;
  assign bus.grant_id    = gid_q;
  assign bus.word_count  = cnt_q;
  assign bus.timeout_err = terr_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single 64-bit-to-byte serializer and UART transmitter between up to four 64-bit word producers, such as the DES pipeline output and a status/diagnostic source. It latches one requester's word, issues a single start pulse to the serializer, and holds off all other requesters until the serializer reports that all eight bytes have been sent. It sits between the producers and the serializer's `start`/`data_in`/`tx_done`-derived completion interface.

## Interface
Parameters:
- `NREQ`, 2, number of requesters; legal range 2..4.
- `TIMEOUT_CYCLES`, 1_000_000, watchdog limit in clock cycles. Used only when `ARB_TIMEOUT_EN` is defined.

Ports:
- `clock`  in  1  system clock, single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  NREQ  per-requester request level.
- `req_data`  in  NREQ*64  requester i's word on bits [64*i+63 : 64*i].
- `ack`  out  NREQ  one-cycle pulse: requester i's word has been latched.
- `ser_data`  out  64  latched word to the serializer.
- `ser_start`  out  1  one-cycle start pulse to the serializer.
- `ser_done`  in  1  one-cycle pulse from the serializer after its last byte is sent.
- `busy`  out  1  high while a word is in flight.
- `grant_id`  out  2  index of the requester currently or last granted.
- `word_count`  out  16  count of completed words; wraps from 0xFFFF to 0.
- `timeout_err`  out  1  sticky watchdog flag; tied to 0 without `ARB_TIMEOUT_EN`.

## Operation
- All outputs are registered.
- Reset values:
  - `ack` = 0, `ser_start` = 0, `busy` = 0, `timeout_err` = 0.
  - `ser_data` = 0, `grant_id` = 0, `word_count` = 0.
  - Priority pointer = 0; state = IDLE.
- **IDLE**
  - Selects the first asserted `req[i]`, searching from the priority pointer upward modulo NREQ.
  - On a selection: latch `req_data[i]` into `ser_data`, set `grant_id` = i, pulse `ack[i]`, pulse `ser_start`, set `busy`, go to WAIT.
- **WAIT**
  - `ser_done` is ignored in the cycle where `ser_start` is high, and honoured from the following cycle.
  - On `ser_done`: increment `word_count`, clear `busy`, set pointer = (grant_id+1) mod NREQ, return to IDLE.
- Requester rules:
  - Hold `req` and data stable until `ack`.
  - A `req` still high in a later IDLE cycle is treated as a new word.
- `req` changes while in WAIT are ignored.
- `ser_data` holds its value until the next grant.
- `req` bits at index ≥ NREQ do not exist; no X-propagation from unused `grant_id` codes.
- A `ser_done` received in IDLE is ignored; it does not increment `word_count`.

## Timing
- Grant latency: `req` sampled high at edge k (in IDLE) → `ack`, `ser_start`, `ser_data`, `grant_id` and `busy` all valid during cycle k+1.
- Release: `ser_done` sampled at edge m (in WAIT) → `busy` = 0 and `word_count` updated in cycle m+1.
  - The earliest next grant has `ser_start` in cycle m+2, so there is at least one idle cycle between words.
- Simultaneous requests: granted strictly in rotation.
  - With all NREQ requesting continuously, each is served once per NREQ words.
- Reset mid-WAIT: returns to IDLE next cycle with all reset values.
  - No `ack` or `ser_start` is issued.
  - `word_count` is cleared.

## Configuration
- Macro `ARB_TIMEOUT_EN`.
- **Defined:**
  - A counter runs while in WAIT.
  - If it reaches `TIMEOUT_CYCLES` without `ser_done`: set `timeout_err` (sticky until reset), clear `busy`, advance the pointer past `grant_id`, return to IDLE.
  - `word_count` is not incremented for the aborted word.
- **Undefined:** WAIT lasts indefinitely until `ser_done`; no counter logic exists; `timeout_err` = 0.

## Test plan
- Reset values: assert `reset` 3 cycles → all outputs at reset values; `ser_done` pulses while in IDLE leave `word_count` = 0.
- Single requester: `req[0]` = 1, data 0x0123456789ABCDEF → `ack[0]` and `ser_start` in the next cycle, `ser_data` = 0x0123456789ABCDEF, `grant_id` = 0; `ser_done` 200 cycles later → `busy` falls, `word_count` = 1.
- Fairness: `req[0]` and `req[1]` held high with NREQ = 2, and 4 `ser_done` pulses returned → grant order 0,1,0,1, `word_count` = 4, exactly one `ack` per grant.
- Early done: `ser_done` asserted in the same cycle as `ser_start` → ignored, `busy` stays 1; a later `ser_done` completes the word.
- Reset mid-WAIT: `reset` asserted 50 cycles after a grant → next cycle IDLE, `busy` = 0, `word_count` = 0, pointer = 0; `req[1]` and `req[0]` then both high → `req[0]` granted first.
- Timeout (`ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 16): no `ser_done` → `timeout_err` = 1 after 16 WAIT cycles, `busy` = 0, next grant goes to the other requester, `word_count` unchanged.
